// File: rtl/commit_trace.sv
// rtl/commit_trace.sv - commit-side trace FIFO with sequence tagging, retire count and PC-continuity check
module commit_trace #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_commit,
    input  logic [63:0]   in_commit_pre_pc,
    input  logic [31:0]   in_commit_instr,
    input  logic [63:0]   in_commit_pc,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [63:0]   out_pre_pc,
    output logic [31:0]   out_instr,
    output logic [63:0]   out_pc,
    output logic [63:0]   out_seq,
    output logic [AW:0]   count,
    output logic [63:0]   retired,
    output logic          overflow,
    output logic          pc_break,
    output logic [63:0]   break_pc
);

    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    logic [63:0] mem_pre_pc_q [DEPTH];
    logic [31:0] mem_instr_q  [DEPTH];
    logic [63:0] mem_pc_q     [DEPTH];
    logic [63:0] mem_seq_q    [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [63:0]   retired_q, retired_d;
    logic          overflow_q, overflow_d;
    logic          pc_break_q, pc_break_d;
    logic [63:0]   break_pc_q, break_pc_d;
    logic [63:0]   last_pc_q, last_pc_d;
    logic          has_prev_q, has_prev_d;
    logic          push, pop, mismatch;

    assign out_valid  = (count_q != '0);
    assign out_pre_pc = mem_pre_pc_q[rd_ptr_q];
    assign out_instr  = mem_instr_q[rd_ptr_q];
    assign out_pc     = mem_pc_q[rd_ptr_q];
    assign out_seq    = mem_seq_q[rd_ptr_q];
    assign count      = count_q;
    assign retired    = retired_q;
    assign overflow   = overflow_q;
    assign pc_break   = pc_break_q;
    assign break_pc   = break_pc_q;

    always_comb begin
        pop      = out_valid && out_ready;
        // A full FIFO still accepts a commit when the head leaves in the same cycle.
        push     = in_commit && ((count_q != FULL) || pop);
        mismatch = in_commit && has_prev_q && (in_commit_pre_pc != last_pc_q);

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        retired_d  = retired_q;
        overflow_d = overflow_q;
        pc_break_d = pc_break_q;
        break_pc_d = break_pc_q;
        last_pc_d  = last_pc_q;
        has_prev_d = has_prev_q;

        if (push) begin
            wr_ptr_d  = wr_ptr_q + AW'(1);
            retired_d = retired_q + 64'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase

        if (in_commit && !push) begin
            overflow_d = 1'b1;
        end
        // Continuity is tracked on every commit, including dropped ones.
        if (mismatch) begin
            pc_break_d = 1'b1;
            if (!pc_break_q) begin
                break_pc_d = in_commit_pre_pc;
            end
        end
        if (in_commit) begin
            last_pc_d  = in_commit_pc;
            has_prev_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            retired_q  <= '0;
            overflow_q <= 1'b0;
            pc_break_q <= 1'b0;
            break_pc_q <= '0;
            last_pc_q  <= '0;
            has_prev_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            retired_q  <= retired_d;
            overflow_q <= overflow_d;
            pc_break_q <= pc_break_d;
            break_pc_q <= break_pc_d;
            last_pc_q  <= last_pc_d;
            has_prev_q <= has_prev_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_pre_pc_q[wr_ptr_q] <= in_commit_pre_pc;
            mem_instr_q[wr_ptr_q]  <= in_commit_instr;
            mem_pc_q[wr_ptr_q]     <= in_commit_pc;
            mem_seq_q[wr_ptr_q]    <= retired_q;
        end
    end

endmodule
